// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU datapath, the debug/loader port, DataMemory and the arbiter.
// slave = arbiter side, master = surrounding environment (CPU, debug port, memory).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_valid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_valid,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_valid,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata,
    input  owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// One-access-per-cycle arbiter for the single-port data memory: CPU vs debug/loader port.
// Round-robin on contention; debug may lock for at most MAX_BURST grants while the CPU waits.
module dmem_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);
  localparam logic       REQ_CPU     = 1'b0;
  localparam logic       REQ_DBG     = 1'b1;
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;
  localparam int         CNT_W       = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic              last_q, last_d;
  logic [0:0]        lock_q, lock_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic              owner_q, owner_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic dbg_wins;
  logic cpu_gnt;
  logic dbg_gnt;

  always_comb begin
    dbg_wins = bus.dbg_req;
    if (bus.cpu_req && bus.dbg_req) begin
      if (lock_q == ST_LOCKED && burst_q < BURST_MAX)
        dbg_wins = 1'b1;
      else
        dbg_wins = (last_q == REQ_CPU);
    end
    cpu_gnt = ~rst & bus.cpu_req & ~dbg_wins;
    dbg_gnt = ~rst & bus.dbg_req &  dbg_wins;
  end

  always_comb begin
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    if (cpu_gnt) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_write = bus.cpu_we;
      bus.mem_read  = ~bus.cpu_we;
    end else if (dbg_gnt) begin
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
      bus.mem_write = bus.dbg_we;
      bus.mem_read  = ~bus.dbg_we;
    end
    bus.cpu_rdata = cpu_gnt ? bus.mem_rdata : {DATA_W{1'b0}};
    bus.cpu_stall = ~rst & bus.cpu_req & ~cpu_gnt;
    bus.dbg_gnt   = dbg_gnt;
    bus.dbg_rdata = dbg_rdata_q;
    bus.dbg_valid = dbg_valid_q;
    bus.owner     = owner_q;
  end

  always_comb begin
    last_d      = last_q;
    owner_d     = owner_q;
    if (cpu_gnt || dbg_gnt) begin
      last_d  = dbg_gnt ? REQ_DBG : REQ_CPU;
      owner_d = dbg_gnt;
    end
    dbg_valid_d = dbg_gnt & ~bus.dbg_we;
    dbg_rdata_d = dbg_valid_d ? bus.mem_rdata : dbg_rdata_q;

    lock_d = lock_q;
    case (lock_q)
      ST_UNLOCKED: if (dbg_gnt && bus.dbg_lock) lock_d = ST_LOCKED;
      ST_LOCKED:   if ((dbg_gnt && !bus.dbg_lock) || !bus.dbg_req) lock_d = ST_UNLOCKED;
      default:     lock_d = ST_UNLOCKED;
    endcase

    // The grant that takes the lock counts as the first burst beat, so the CPU waits at most MAX_BURST.
    burst_d = burst_q;
    if (cpu_gnt || lock_d == ST_UNLOCKED)
      burst_d = '0;
    else if (dbg_gnt && bus.dbg_lock && bus.cpu_req && burst_q < BURST_MAX)
      burst_d = burst_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= REQ_DBG;
      lock_q      <= ST_UNLOCKED;
      burst_q     <= '0;
      owner_q     <= 1'b0;
      dbg_valid_q <= 1'b0;
      dbg_rdata_q <= {DATA_W{1'b0}};
    end else begin
      last_q      <= last_d;
      lock_q      <= lock_d;
      burst_q     <= burst_d;
      owner_q     <= owner_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
endmodule
